// File: rtl/jump_target_gen.sv
// jump_target_gen: decode-stage control-transfer target generator.
// Classifies JAL / conditional branch / none (32-bit and RVC forms), extracts and
// sign-extends the offset, and produces pc+offset and the fall-through pc through
// a 2-stage valid/ready pipeline with flush.
// Optional macro JTG_MISALIGN_CHK_EN adds out_misalign (target[1] set on a transfer).
module jump_target_gen #(
    parameter int XLEN    = 32,
    parameter bit RVC_JAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_kind,
    output logic            out_link,
    output logic            out_rvc,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_next_pc
`ifdef JTG_MISALIGN_CHK_EN
    ,
    output logic            out_misalign
`endif
);

    // On RV64 the C.JAL encoding is reused by C.ADDIW, so it never decodes as a jump.
    localparam bit RVC_JAL_EFF = (XLEN == 64) ? 1'b0 : RVC_JAL;

    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_JAL    = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;

    localparam logic [XLEN-1:0] STEP_RVC = XLEN'(2);
    localparam logic [XLEN-1:0] STEP_STD = XLEN'(4);

    // JAL: imm[20|10:1|11|19:12] in instr[31:12]
    function automatic logic signed [XLEN-1:0] jal_off(input logic [31:12] b);
        logic [20:0] raw;
        raw = {b[31], b[19:12], b[20], b[30:21], 1'b0};
        return {{(XLEN-21){raw[20]}}, raw};
    endfunction

    // Bcc: imm[12|10:5] in instr[31:25], imm[4:1|11] in instr[11:7]
    function automatic logic signed [XLEN-1:0] br_off(input logic [31:25] hi,
                                                      input logic [11:7]  lo);
        logic [12:0] raw;
        raw = {hi[31], lo[7], hi[30:25], lo[11:8], 1'b0};
        return {{(XLEN-13){raw[12]}}, raw};
    endfunction

    // C.J / C.JAL: 12-bit scrambled offset in instr[12:2]
    function automatic logic signed [XLEN-1:0] cj_off(input logic [12:2] b);
        logic [11:0] raw;
        raw = {b[12], b[8], b[10:9], b[6], b[7], b[2], b[11], b[5:3], 1'b0};
        return {{(XLEN-12){raw[11]}}, raw};
    endfunction

    // C.BEQZ / C.BNEZ: 9-bit offset split around the rs1' field
    function automatic logic signed [XLEN-1:0] cb_off(input logic [12:10] hi,
                                                      input logic [6:2]   lo);
        logic [8:0] raw;
        raw = {hi[12], lo[6:5], lo[2], hi[11:10], lo[4:3], 1'b0};
        return {{(XLEN-9){raw[8]}}, raw};
    endfunction

    // Stage p0: combinational decode of the presented instruction
    logic [1:0]             kind_p0;
    logic                   link_p0;
    logic                   rvc_p0;
    logic signed [XLEN-1:0] off_p0;

    // Stage p1 registers
    logic                   vld_p1;
    logic [1:0]             kind_p1;
    logic                   link_p1;
    logic                   rvc_p1;
    logic signed [XLEN-1:0] off_p1;
    logic [XLEN-1:0]        pc_p1;

    // Stage p2 valid (the remaining p2 state is the out_* registers)
    logic                   vld_p2;

    logic                   adv_p1;
    logic                   adv_p2;
    logic                   take_p0;
    logic [XLEN-1:0]        target_p1;
    logic [XLEN-1:0]        next_pc_p1;

    assign adv_p2    = !vld_p2 || out_ready;
    assign adv_p1    = !vld_p1 || adv_p2;
    assign in_ready  = adv_p1 && !flush && !rst;
    assign take_p0   = in_valid && in_ready;
    assign out_valid = vld_p2;

    // Decode: classify the instruction and pick the matching offset format
    always_comb begin
        kind_p0 = KIND_NONE;
        link_p0 = 1'b0;
        rvc_p0  = (in_instr[1:0] != 2'b11);
        off_p0  = '0;
        if (!rvc_p0) begin
            if (in_instr[6:0] == 7'b1101111) begin
                kind_p0 = KIND_JAL;
                link_p0 = (in_instr[11:7] != 5'd0);
                off_p0  = jal_off(in_instr[31:12]);
            end else if (in_instr[6:0] == 7'b1100011 && in_instr[14:13] != 2'b01) begin
                kind_p0 = KIND_BRANCH;
                off_p0  = br_off(in_instr[31:25], in_instr[11:7]);
            end
        end else if (in_instr[1:0] == 2'b01) begin
            case (in_instr[15:13])
                3'b101: begin
                    kind_p0 = KIND_JAL;
                    off_p0  = cj_off(in_instr[12:2]);
                end
                3'b001: begin
                    if (RVC_JAL_EFF) begin
                        kind_p0 = KIND_JAL;
                        link_p0 = 1'b1;
                        off_p0  = cj_off(in_instr[12:2]);
                    end
                end
                3'b110, 3'b111: begin
                    kind_p0 = KIND_BRANCH;
                    off_p0  = cb_off(in_instr[12:10], in_instr[6:2]);
                end
                default: begin
                    kind_p0 = KIND_NONE;
                end
            endcase
        end
    end

    // Pipeline occupancy: flush and reset both empty the pipe
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv_p1) vld_p1 <= in_valid;
            if (adv_p2) vld_p2 <= vld_p1;
        end
    end

    // Stage p0 -> p1: capture decode results and pc on an accepted transfer
    always_ff @(posedge clk) begin
        if (take_p0) begin
            kind_p1 <= kind_p0;
            link_p1 <= link_p0;
            rvc_p1  <= rvc_p0;
            off_p1  <= off_p0;
            pc_p1   <= in_pc;
        end
    end

    assign target_p1  = pc_p1 + $unsigned(off_p1);
    assign next_pc_p1 = pc_p1 + (rvc_p1 ? STEP_RVC : STEP_STD);

    // Stage p1 -> p2: output registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_kind    <= KIND_NONE;
            out_link    <= 1'b0;
            out_rvc     <= 1'b0;
            out_target  <= '0;
            out_next_pc <= '0;
        end else if (adv_p2 && vld_p1) begin
            out_kind    <= kind_p1;
            out_link    <= link_p1;
            out_rvc     <= rvc_p1;
            out_target  <= target_p1;
            out_next_pc <= next_pc_p1;
        end
    end

`ifdef JTG_MISALIGN_CHK_EN
    // Stage p1 -> p2: flag transfers whose target is only halfword aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            out_misalign <= 1'b0;
        end else if (adv_p2 && vld_p1) begin
            out_misalign <= (kind_p1 != KIND_NONE) && target_p1[1];
        end
    end
`endif

endmodule
